handshake_encoder: RTL and testbench

Transmit-side UDT handshake packet builder. Accepts one handshake request as a flat field bundle over a valid/ready command port and serialises it into a fixed 64-byte UDT control packet (16-byte header + 48-byte handshake body) on a 64-bit AXI-stream master. It sits between the socket manager's connection logic, which decides field values, and the UDP/IP transmit path. It is the emitting counterpart of the handshake stream that the socket manager consumes.

---
 rtl/udt_pkg.sv | 34 +++
 rtl/handshake_encoder.sv | 126 ++++++++++++
 tb/tb_handshake_encoder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// udt_pkg: constants and types shared between the UDT handshake encoder
// (transmit side) and the socket manager's handshake parser (receive side).
//   UDT_CTRL_HANDSHAKE : first header word of a handshake control packet
//   UDT_HS_BEATS       : 64-bit beats per handshake packet (64 bytes)
//   UDT_CONN_REQ/RSP   : conn_type values (1 / -1 in two's complement)
//   SOCK_STREAM/DGRAM  : socket type field values
//   udt_hs_fields_t    : flat 384-bit handshake field bundle
package udt_pkg;

    localparam logic [31:0] UDT_CTRL_HANDSHAKE = 32'h8000_0000;
    localparam int unsigned UDT_HS_BEATS       = 8;
    localparam logic [31:0] UDT_CONN_REQ       = 32'h0000_0001;
    localparam logic [31:0] UDT_CONN_RSP       = 32'hFFFF_FFFF;
    localparam logic [31:0] SOCK_STREAM        = 32'd1;
    localparam logic [31:0] SOCK_DGRAM         = 32'd2;

    typedef struct packed {
        logic [31:0]  timestamp;
        logic [31:0]  dst_sock_id;
        logic [31:0]  isn;
        logic [31:0]  mss;
        logic [31:0]  flight_size;
        logic [31:0]  conn_type;
        logic [31:0]  sock_id;
        logic [31:0]  syn_cookie;
        logic [127:0] peer_ip;
    } udt_hs_fields_t;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_SEND = 1'b1
    } hs_enc_state_t;

endpackage

// File: rtl/handshake_encoder.sv
// handshake_encoder: builds a 64-byte UDT handshake control packet from one
// field bundle and streams it as eight big-endian 64-bit AXI-stream beats.
// Ports:
//   core_clk, core_rst_n      : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     : command handshake for the cmd_* field bundle
//   cmd_timestamp .. cmd_peer_ip : handshake field values (captured on accept)
//   hs_tdata/tkeep/tvalid/tlast, hs_tready : AXI-stream master
//   tx_count                  : completed packets, wraps modulo 2^32
module handshake_encoder
    import udt_pkg::*;
#(
    parameter logic [31:0] UDT_VERSION = 32'd4,
    parameter logic [31:0] SOCK_TYPE   = SOCK_STREAM
) (
    input  logic           core_clk,
    input  logic           core_rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [31:0]    cmd_timestamp,
    input  logic [31:0]    cmd_dst_sock_id,
    input  logic [31:0]    cmd_isn,
    input  logic [31:0]    cmd_mss,
    input  logic [31:0]    cmd_flight_size,
    input  logic [31:0]    cmd_conn_type,
    input  logic [31:0]    cmd_sock_id,
    input  logic [31:0]    cmd_syn_cookie,
    input  logic [127:0]   cmd_peer_ip,
    output logic [63:0]    hs_tdata,
    output logic [7:0]     hs_tkeep,
    output logic           hs_tvalid,
    input  logic           hs_tready,
    output logic           hs_tlast,
    output logic [31:0]    tx_count
);

    localparam logic [2:0] LAST_BEAT = 3'(UDT_HS_BEATS - 1);

    hs_enc_state_t  state_q, state_d;
    logic [2:0]     beat_q, beat_d;
    udt_hs_fields_t hold_q;
    logic [31:0]    tx_count_q;
    logic           cmd_fire;
    logic           last_fire;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign last_fire = hs_tvalid && hs_tready && (beat_q == LAST_BEAT);
    assign tx_count  = tx_count_q;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q    <= HS_IDLE;
            beat_q     <= '0;
            hold_q     <= '0;
            tx_count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (cmd_fire) begin
                hold_q.timestamp   <= cmd_timestamp;
                hold_q.dst_sock_id <= cmd_dst_sock_id;
                hold_q.isn         <= cmd_isn;
                hold_q.mss         <= cmd_mss;
                hold_q.flight_size <= cmd_flight_size;
                hold_q.conn_type   <= cmd_conn_type;
                hold_q.sock_id     <= cmd_sock_id;
                hold_q.syn_cookie  <= cmd_syn_cookie;
                hold_q.peer_ip     <= cmd_peer_ip;
            end
            if (last_fire) begin
                tx_count_q <= tx_count_q + 32'd1;
            end
        end
    end

    // Handshake outputs come straight from the state, so hs_tvalid never
    // depends on hs_tready and everything drops as soon as reset asserts.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cmd_ready = 1'b0;
        hs_tvalid = 1'b0;
        case (state_q)
            HS_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = HS_SEND;
                    beat_d  = '0;
                end
            end
            HS_SEND: begin
                hs_tvalid = 1'b1;
                if (hs_tready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = HS_IDLE;
                    end
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    always_comb begin
        hs_tdata = '0;
        hs_tkeep = '0;
        hs_tlast = 1'b0;
        if (hs_tvalid) begin
            hs_tkeep = '1;
            hs_tlast = (beat_q == LAST_BEAT);
            case (beat_q)
                3'd0: hs_tdata = {UDT_CTRL_HANDSHAKE, 32'h0};
                3'd1: hs_tdata = {hold_q.timestamp, hold_q.dst_sock_id};
                3'd2: hs_tdata = {UDT_VERSION, SOCK_TYPE};
                3'd3: hs_tdata = {hold_q.isn, hold_q.mss};
                3'd4: hs_tdata = {hold_q.flight_size, hold_q.conn_type};
                3'd5: hs_tdata = {hold_q.sock_id, hold_q.syn_cookie};
                3'd6: hs_tdata = hold_q.peer_ip[127:64];
                3'd7: hs_tdata = hold_q.peer_ip[63:0];
                default: hs_tdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_encoder.sv
// tb_handshake_encoder: self-checking bench for handshake_encoder.
// Reference model: the whole 512-bit packet is assembled from the field
// bundle and beat i is the i-th 64-bit slice from the top.
module tb_handshake_encoder;
    import udt_pkg::*;

    logic           core_clk = 1'b0;
    logic           core_rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [31:0]    cmd_timestamp = '0;
    logic [31:0]    cmd_dst_sock_id = '0;
    logic [31:0]    cmd_isn = '0;
    logic [31:0]    cmd_mss = '0;
    logic [31:0]    cmd_flight_size = '0;
    logic [31:0]    cmd_conn_type = '0;
    logic [31:0]    cmd_sock_id = '0;
    logic [31:0]    cmd_syn_cookie = '0;
    logic [127:0]   cmd_peer_ip = '0;
    logic [63:0]    hs_tdata;
    logic [7:0]     hs_tkeep;
    logic           hs_tvalid;
    logic           hs_tready = 1'b0;
    logic           hs_tlast;
    logic [31:0]    tx_count;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [31:0] tx_expected = '0;

    handshake_encoder #(
        .UDT_VERSION(32'd4),
        .SOCK_TYPE  (32'd1)
    ) dut (
        .core_clk       (core_clk),
        .core_rst_n     (core_rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_timestamp  (cmd_timestamp),
        .cmd_dst_sock_id(cmd_dst_sock_id),
        .cmd_isn        (cmd_isn),
        .cmd_mss        (cmd_mss),
        .cmd_flight_size(cmd_flight_size),
        .cmd_conn_type  (cmd_conn_type),
        .cmd_sock_id    (cmd_sock_id),
        .cmd_syn_cookie (cmd_syn_cookie),
        .cmd_peer_ip    (cmd_peer_ip),
        .hs_tdata       (hs_tdata),
        .hs_tkeep       (hs_tkeep),
        .hs_tvalid      (hs_tvalid),
        .hs_tready      (hs_tready),
        .hs_tlast       (hs_tlast),
        .tx_count       (tx_count)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int unsigned beat;
        logic [63:0] data;
        logic        last;
    } vec_t;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_beat(input udt_hs_fields_t f, input int unsigned i);
        logic [511:0] pkt;
        pkt = {UDT_CTRL_HANDSHAKE, 32'h0,
               f.timestamp, f.dst_sock_id,
               32'd4, 32'd1,
               f.isn, f.mss,
               f.flight_size, f.conn_type,
               f.sock_id, f.syn_cookie,
               f.peer_ip};
        return pkt[511 - 64*i -: 64];
    endfunction

    function automatic udt_hs_fields_t rand_fields();
        udt_hs_fields_t f;
        f.timestamp   = $urandom;
        f.dst_sock_id = $urandom;
        f.isn         = $urandom;
        f.mss         = $urandom;
        f.flight_size = $urandom;
        f.conn_type   = ($urandom_range(0, 1) == 0) ? UDT_CONN_REQ : UDT_CONN_RSP;
        f.sock_id     = $urandom;
        f.syn_cookie  = $urandom;
        f.peer_ip     = {$urandom, $urandom, $urandom, $urandom};
        return f;
    endfunction

    task automatic set_fields(input udt_hs_fields_t f);
        cmd_timestamp   = f.timestamp;
        cmd_dst_sock_id = f.dst_sock_id;
        cmd_isn         = f.isn;
        cmd_mss         = f.mss;
        cmd_flight_size = f.flight_size;
        cmd_conn_type   = f.conn_type;
        cmd_sock_id     = f.sock_id;
        cmd_syn_cookie  = f.syn_cookie;
        cmd_peer_ip     = f.peer_ip;
    endtask

    // Entered #1 after the edge that accepted f. stall_mode: 0 = ready always,
    // 1 = ready pattern 1,0,0 repeating, 2 = random ready. Returns at the
    // negedge following acceptance of the last beat.
    task automatic collect_packet(input udt_hs_fields_t f, input int unsigned stall_mode,
                                  input string tag, output logic [7:0][63:0] got);
        int unsigned beat;
        int unsigned cyc;
        logic        rdy;
        logic        prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        beat = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        got = '0;
        while (beat < UDT_HS_BEATS && cyc < 200) begin
            @(negedge core_clk);
            cyc++;
            chk1({tag, "_tvalid"}, hs_tvalid, 1'b1);
            chk1({tag, "_cmd_ready_busy"}, cmd_ready, 1'b0);
            if (prev_stall) begin
                chk64({tag, "_stall_data"}, hs_tdata, prev_data);
                chk1({tag, "_stall_last"}, hs_tlast, prev_last);
            end
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            hs_tready = rdy;
            if (hs_tvalid && rdy) begin
                got[beat] = hs_tdata;
                chk64($sformatf("%s_beat%0d", tag, beat), hs_tdata, model_beat(f, beat));
                chk1($sformatf("%s_last%0d", tag, beat), hs_tlast, beat == UDT_HS_BEATS - 1);
                chk64($sformatf("%s_keep%0d", tag, beat), {56'h0, hs_tkeep}, 64'hFF);
                beat++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = hs_tvalid;
            end
            prev_data = hs_tdata;
            prev_last = hs_tlast;
        end
        if (beat < UDT_HS_BEATS) begin
            chk64({tag, "_timeout_beats"}, 64'(beat), 64'(UDT_HS_BEATS));
        end
        if (stall_mode == 0) begin
            chk64({tag, "_cycles"}, 64'(cyc), 64'(UDT_HS_BEATS));
        end
        tx_expected = tx_expected + 32'd1;
        @(negedge core_clk);
        hs_tready = 1'b0;
        chk1({tag, "_done_tvalid"}, hs_tvalid, 1'b0);
        chk1({tag, "_done_ready"}, cmd_ready, 1'b1);
        chk64({tag, "_tx_count"}, {32'h0, tx_count}, {32'h0, tx_expected});
    endtask

    // Starts at a negedge with the encoder idle; fields are scrambled right
    // after acceptance to show the packet uses the captured copy.
    task automatic run_packet(input udt_hs_fields_t f, input int unsigned stall_mode,
                              input string tag, output logic [7:0][63:0] got);
        set_fields(f);
        cmd_valid = 1'b1;
        chk1({tag, "_ready"}, cmd_ready, 1'b1);
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0;
        set_fields(rand_fields());
        collect_packet(f, stall_mode, tag, got);
    endtask

    initial begin
        udt_hs_fields_t   f0, f1, f2;
        logic [7:0][63:0] got;
        vec_t             vecs[8];

        f0.timestamp   = 32'h0000_1000;
        f0.dst_sock_id = 32'h0;
        f0.isn         = 32'h1234_5678;
        f0.mss         = 32'd1500;
        f0.flight_size = 32'd25600;
        f0.conn_type   = UDT_CONN_REQ;
        f0.sock_id     = 32'hABCD_0001;
        f0.syn_cookie  = 32'hDEAD_BEEF;
        f0.peer_ip     = 128'h0A00_0001;

        vecs[0] = '{0, 64'h8000_0000_0000_0000, 1'b0};
        vecs[1] = '{1, 64'h0000_1000_0000_0000, 1'b0};
        vecs[2] = '{2, 64'h0000_0004_0000_0001, 1'b0};
        vecs[3] = '{3, 64'h1234_5678_0000_05DC, 1'b0};
        vecs[4] = '{4, 64'h0000_6400_0000_0001, 1'b0};
        vecs[5] = '{5, 64'hABCD_0001_DEAD_BEEF, 1'b0};
        vecs[6] = '{6, 64'h0000_0000_0000_0000, 1'b0};
        vecs[7] = '{7, 64'h0000_0000_0A00_0001, 1'b1};

        // Reset state
        #1;
        chk1("rst_tvalid", hs_tvalid, 1'b0);
        chk1("rst_tlast", hs_tlast, 1'b0);
        chk64("rst_tdata", hs_tdata, 64'h0);
        chk64("rst_tkeep", {56'h0, hs_tkeep}, 64'h0);
        chk64("rst_tx_count", {32'h0, tx_count}, 64'h0);
        repeat (3) @(negedge core_clk);
        core_rst_n = 1'b1;
        @(negedge core_clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);

        // Directed packet against a constant table
        run_packet(f0, 0, "directed", got);
        for (int unsigned i = 0; i < 8; i++) begin
            chk64($sformatf("table_beat%0d", vecs[i].beat), got[vecs[i].beat], vecs[i].data);
        end

        // Stalled packet, ready pattern 1,0,0
        run_packet(rand_fields(), 1, "stall", got);

        // Second command pending during the first packet
        f1 = rand_fields();
        f2 = rand_fields();
        set_fields(f1);
        cmd_valid = 1'b1;
        @(posedge core_clk);
        #1;
        set_fields(f2);
        collect_packet(f1, 0, "b2b_first", got);
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0;
        set_fields(rand_fields());
        collect_packet(f2, 0, "b2b_second", got);

        // Random traffic
        for (int unsigned n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge core_clk);
            run_packet(rand_fields(), 2, $sformatf("rand%0d", n), got);
        end

        // Reset in the middle of a packet
        f1 = rand_fields();
        set_fields(f1);
        cmd_valid = 1'b1;
        hs_tready = 1'b1;
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(negedge core_clk);
        chk64("midrst_beat4", hs_tdata, model_beat(f1, 4));
        core_rst_n = 1'b0;
        #1;
        chk1("midrst_tvalid", hs_tvalid, 1'b0);
        chk1("midrst_tlast", hs_tlast, 1'b0);
        chk64("midrst_tdata", hs_tdata, 64'h0);
        chk64("midrst_tkeep", {56'h0, hs_tkeep}, 64'h0);
        chk64("midrst_tx_count", {32'h0, tx_count}, 64'h0);
        hs_tready = 1'b0;
        tx_expected = '0;
        @(negedge core_clk);
        core_rst_n = 1'b1;
        repeat (2) begin
            @(negedge core_clk);
            chk1("midrst_no_resume", hs_tvalid, 1'b0);
        end
        run_packet(rand_fields(), 0, "after_rst", got);

        // Counter wrap
        force dut.tx_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.tx_count_q;
        chk64("wrap_preload", {32'h0, tx_count}, 64'hFFFF_FFFF);
        tx_expected = 32'hFFFF_FFFF;
        @(negedge core_clk);
        run_packet(rand_fields(), 0, "wrap", got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
